// File: rtl/prbs7_bert_ctrl_if.sv
// Control and data bundle between a link receiver and the PRBS7 BERT controller.
// The master side drives the test requests and the received bit stream. The
// slave side (the controller) returns its status and error count.
interface prbs7_bert_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             din;
    logic             din_vld;
    logic             busy;
    logic             locked;
    logic             done;
    logic             lock_fail;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output start, abort, din, din_vld,
        input  busy, locked, done, lock_fail, err_cnt
    );

    modport slave (
        input  start, abort, din, din_vld,
        output busy, locked, done, lock_fail, err_cnt
    );
endinterface

// File: rtl/prbs7_bert_ctrl.sv
// PRBS7 (x^7+x^6+1) bit-error-rate test controller.
// The controller first seeds a local reference from the received stream and
// waits for LOCK_LEN consecutive predicted bits. It then lets the reference
// free-run and counts mismatches over a WIN_LEN-bit window.
// All status outputs are flops loaded from next-state values, so no input
// reaches an output combinationally.
module prbs7_bert_ctrl #(
    parameter int LOCK_LEN = 16,
    parameter int ACQ_TO   = 256,
    parameter int WIN_LEN  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    prbs7_bert_ctrl_if.slave bus
);

    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int AW = $clog2(ACQ_TO + 1);
    localparam int BW = $clog2(WIN_LEN + 1);

    // Counters hold "bits accepted so far". The terminal value is one below
    // the limit, because the edge that accepts the last bit makes the transition.
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_LEN - 1);
    localparam logic [AW-1:0]    ACQ_LAST  = AW'(ACQ_TO - 1);
    localparam logic [BW-1:0]    WIN_LAST  = BW'(WIN_LEN - 1);
    localparam logic [MW-1:0]    M_ONE     = MW'(1);
    localparam logic [AW-1:0]    A_ONE     = AW'(1);
    localparam logic [BW-1:0]    B_ONE     = BW'(1);
    localparam logic [CNT_W-1:0] E_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] E_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        ACQ,
        MEAS,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       sr_q, sr_d;
    logic [2:0]       seed_q, seed_d;
    logic [MW-1:0]    match_q, match_d;
    logic [AW-1:0]    acq_q, acq_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             done_q, done_d;
    logic             pred;

    assign pred = sr_q[6] ^ sr_q[5];

    // Next-state, reference, counter and status computation.
    always_comb begin
        // NOTE: every value assigned here gets a default first, so no latch is inferred.
        state_d = state_q;
        sr_d    = sr_q;
        seed_d  = seed_q;
        match_d = match_q;
        acq_d   = acq_q;
        bit_d   = bit_q;
        err_d   = err_q;
        fail_d  = fail_q;

        if (bus.abort) begin
            // Abort wins over everything. The error count is kept for inspection.
            state_d = IDLE;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = SEED;
                        sr_d    = '0;
                        seed_d  = '0;
                        match_d = '0;
                        acq_d   = '0;
                        bit_d   = '0;
                        err_d   = '0;
                        fail_d  = 1'b0;
                    end
                end
                SEED: begin
                    if (bus.din_vld) begin
                        sr_d   = {sr_q[5:0], bus.din};
                        seed_d = seed_q + 3'd1;
                        if (seed_q == 3'd6) state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (bus.din_vld) begin
                        // Self-synchronising: the received bit feeds the reference.
                        sr_d  = {sr_q[5:0], bus.din};
                        acq_d = acq_q + A_ONE;
                        if (bus.din == pred && sr_q != 7'd0) begin
                            match_d = match_q + M_ONE;
                            if (match_q == LOCK_LAST) state_d = MEAS;
                        end else begin
                            match_d = '0;
                        end
                        // A lock on the same edge takes precedence over the timeout.
                        if (state_d != MEAS && acq_q == ACQ_LAST) begin
                            state_d = DONE;
                            fail_d  = 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (bus.din_vld) begin
                        // Free-run on the prediction, so a received error does not
                        // corrupt later predictions.
                        sr_d  = {sr_q[5:0], pred};
                        bit_d = bit_q + B_ONE;
                        if (bus.din != pred && err_q != E_MAX) err_d = err_q + E_ONE;
                        if (bit_q == WIN_LAST) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d   = (state_d == SEED) || (state_d == ACQ) || (state_d == MEAS);
        done_d   = (state_d == DONE);
        locked_d = (state_d == MEAS) || ((state_d == DONE) && !fail_d);
    end

    // State, reference and counter registers, plus the registered status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            seed_q   <= '0;
            match_q  <= '0;
            acq_q    <= '0;
            bit_q    <= '0;
            err_q    <= '0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
            state_q  <= state_d;
            sr_q     <= sr_d;
            seed_q   <= seed_d;
            match_q  <= match_d;
            acq_q    <= acq_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.locked    = locked_q;
    assign bus.done      = done_q;
    assign bus.lock_fail = fail_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_prbs7_bert_ctrl.sv
// Self-checking bench for prbs7_bert_ctrl.
// Two instances share one stimulus: one with a 16-bit error counter and one with
// a 4-bit counter, so the 4-bit one shows saturation. Expected values come from
// a transmitter-side PRBS7 recurrence and plain bit-position arithmetic.
module tb_prbs7_bert_ctrl;

    localparam int LOCK_LEN = 16;
    localparam int ACQ_TO   = 256;
    localparam int WIN_LEN  = 1024;
    localparam int LOCK_AT  = 7 + LOCK_LEN;
    localparam int TOTAL    = LOCK_AT + WIN_LEN;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fails;
    bit   gap_en;
    bit   tx[$];

    prbs7_bert_ctrl_if #(.CNT_W(16)) bus ();
    prbs7_bert_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.start   = bus.start;
    assign bus4.abort   = bus.abort;
    assign bus4.din     = bus.din;
    assign bus4.din_vld = bus.din_vld;

    prbs7_bert_ctrl #(.LOCK_LEN(LOCK_LEN), .ACQ_TO(ACQ_TO), .WIN_LEN(WIN_LEN), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    prbs7_bert_ctrl #(.LOCK_LEN(LOCK_LEN), .ACQ_TO(ACQ_TO), .WIN_LEN(WIN_LEN), .CNT_W(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmitter sequence: b[n] = b[n-7] ^ b[n-6], the first seven bits taken from the seed.
    task automatic gen_prbs(input logic [6:0] seed, input int len);
        tx.delete();
        for (int n = 0; n < len; n++) begin
            if (n < 7) tx.push_back(seed[6-n]);
            else       tx.push_back(tx[n-7] ^ tx[n-6]);
        end
    endtask

    // One clock: drive on the falling edge, observe 1 time unit after the rising edge.
    task automatic tick(input logic s, input logic a, input logic b, input logic v);
        @(negedge clk);
        bus.start   = s;
        bus.abort   = a;
        bus.din     = b;
        bus.din_vld = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // One valid bit, optionally preceded by random invalid cycles carrying garbage.
    task automatic send_valid(input logic b, input logic s);
        if (gap_en) begin
            int g;
            g = int'($urandom_range(0, 3));
            for (int i = 0; i < g; i++) tick(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
        tick(s, 1'b0, b, 1'b1);
    endtask

    // Full lock plus window run with optional flips, inversion, an ignored start, or an abort.
    task automatic run_window(input string name, input logic [6:0] seed, input int nflip,
                              input bit invert, input int start_at, input int abort_at,
                              input bit abort_start, output int errs);
        bit         flip_at[WIN_LEN];
        int         slot;
        int         e16;
        int         e4;
        logic [3:0] exp_st;
        errs = 0;
        gen_prbs(seed, TOTAL);
        if (nflip > 0) begin
            slot = WIN_LEN / nflip;
            for (int i = 0; i < nflip; i++)
                flip_at[i*slot + int'($urandom_range(1, slot - 2))] = 1'b1;
        end

        tick(1'b1, 1'b0, 1'($urandom), 1'b0);
        n_checks++;
        if ({bus.busy, bus.locked, bus.done, bus.lock_fail, bus.err_cnt} !== {4'b1000, 16'd0} ||
            {bus4.busy, bus4.locked, bus4.done, bus4.lock_fail, bus4.err_cnt} !== {4'b1000, 4'd0})
            begin
            n_fails++;
            $display("FAIL %s start: got st=%b err=%0d / st4=%b err4=%0d, expected st=1000 err=0",
                     name, {bus.busy, bus.locked, bus.done, bus.lock_fail}, bus.err_cnt,
                     {bus4.busy, bus4.locked, bus4.done, bus4.lock_fail}, bus4.err_cnt);
        end

        for (int k = 1; k <= TOTAL; k++) begin
            bit b;
            int m;
            b = tx[k-1];
            m = k - LOCK_AT - 1;
            e16 = (errs > 65535) ? 65535 : errs;
            e4  = (errs > 15) ? 15 : errs;
            if (abort_at >= 0 && m == abort_at) begin
                tick(abort_start, 1'b1, 1'($urandom), 1'b1);
                n_checks++;
                if ({bus.busy, bus.locked, bus.done, bus.lock_fail,
                     bus4.busy, bus4.locked, bus4.done, bus4.lock_fail} !== 8'h00) begin
                    n_fails++;
                    $display("FAIL %s abort status: got %b / %b, expected 0000",
                             name, {bus.busy, bus.locked, bus.done, bus.lock_fail},
                             {bus4.busy, bus4.locked, bus4.done, bus4.lock_fail});
                end
                n_checks++;
                if (bus.err_cnt !== 16'(e16) || bus4.err_cnt !== 4'(e4)) begin
                    n_fails++;
                    $display("FAIL %s abort err_cnt kept: got %0d / %0d, expected %0d / %0d",
                             name, bus.err_cnt, bus4.err_cnt, e16, e4);
                end
                return;
            end
            if (m >= 0 && (invert || flip_at[m])) begin
                b = ~b;
                errs++;
            end
            send_valid(b, logic'(k == start_at));
            e16 = (errs > 65535) ? 65535 : errs;
            e4  = (errs > 15) ? 15 : errs;
            exp_st = {logic'(k < TOTAL), logic'(k >= LOCK_AT), logic'(k >= TOTAL), 1'b0};
            n_checks++;
            if ({bus.busy, bus.locked, bus.done, bus.lock_fail,
                 bus4.busy, bus4.locked, bus4.done, bus4.lock_fail} !== {exp_st, exp_st}) begin
                n_fails++;
                $display("FAIL %s status at bit %0d: got %b / %b, expected %b",
                         name, k, {bus.busy, bus.locked, bus.done, bus.lock_fail},
                         {bus4.busy, bus4.locked, bus4.done, bus4.lock_fail}, exp_st);
            end
            n_checks++;
            if (bus.err_cnt !== 16'(e16) || bus4.err_cnt !== 4'(e4)) begin
                n_fails++;
                $display("FAIL %s err_cnt at bit %0d: got %0d / %0d, expected %0d / %0d",
                         name, k, bus.err_cnt, bus4.err_cnt, e16, e4);
            end
        end

        // Results hold in DONE whatever arrives on din.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            n_checks++;
            if ({bus.busy, bus.locked, bus.done, bus.lock_fail} !== 4'b0110 ||
                bus.err_cnt !== 16'(e16) || bus4.err_cnt !== 4'(e4)) begin
                n_fails++;
                $display("FAIL %s done hold: got st=%b err=%0d/%0d, expected st=0110 err=%0d/%0d",
                         name, {bus.busy, bus.locked, bus.done, bus.lock_fail},
                         bus.err_cnt, bus4.err_cnt, e16, e4);
            end
        end
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.din     = 1'b0;
        bus.din_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.locked, bus.done, bus.lock_fail, bus.err_cnt, bus4.err_cnt} !== 24'd0) begin
            n_fails++;
            $display("FAIL reset values: got st=%b err=%0d err4=%0d, expected all zero",
                     {bus.busy, bus.locked, bus.done, bus.lock_fail}, bus.err_cnt, bus4.err_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({bus.busy, bus.locked, bus.done, bus.lock_fail, bus.err_cnt} !== 20'd0) begin
            n_fails++;
            $display("FAIL idle after reset: got st=%b err=%0d, expected all zero",
                     {bus.busy, bus.locked, bus.done, bus.lock_fail}, bus.err_cnt);
        end
    endtask

    task automatic test_clean_lock();
        int e;
        run_window("clean_lock", 7'h7F, 0, 1'b0, 3, -1, 1'b0, e);
    endtask

    task automatic test_error_count();
        int e;
        run_window("five_flips", 7'($urandom_range(1, 127)), 5, 1'b0, -1, -1, 1'b0, e);
    endtask

    task automatic test_all_zero();
        logic [3:0] exp_st;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7 + ACQ_TO; k++) begin
            send_valid(1'b0, 1'b0);
            exp_st = {logic'(k < 7 + ACQ_TO), 1'b0, logic'(k >= 7 + ACQ_TO), logic'(k >= 7 + ACQ_TO)};
            n_checks++;
            if ({bus.busy, bus.locked, bus.done, bus.lock_fail} !== exp_st ||
                bus.err_cnt !== 16'd0) begin
                n_fails++;
                $display("FAIL all_zero at bit %0d: got st=%b err=%0d, expected st=%b err=0",
                         k, {bus.busy, bus.locked, bus.done, bus.lock_fail}, bus.err_cnt, exp_st);
            end
        end
    endtask

    task automatic test_saturation();
        int e;
        run_window("inverted", 7'($urandom_range(1, 127)), 0, 1'b1, -1, -1, 1'b0, e);
    endtask

    task automatic test_abort();
        int e;
        int e4;
        run_window("abort_meas", 7'($urandom_range(1, 127)), 4, 1'b0, -1, 500, 1'b0, e);
        e4 = (e > 15) ? 15 : e;
        // start together with abort in IDLE stays in IDLE.
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({bus.busy, bus.locked, bus.done, bus.lock_fail} !== 4'b0000 ||
            bus.err_cnt !== 16'(e) || bus4.err_cnt !== 4'(e4)) begin
            n_fails++;
            $display("FAIL start_abort idle: got st=%b err=%0d, expected st=0000 err=%0d",
                     {bus.busy, bus.locked, bus.done, bus.lock_fail}, bus.err_cnt, e);
        end
        run_window("relock", 7'($urandom_range(1, 127)), 0, 1'b0, -1, -1, 1'b0, e);
        run_window("start_abort_meas", 7'($urandom_range(1, 127)), 0, 1'b0, -1, 10, 1'b1, e);
    endtask

    task automatic test_gaps();
        int e;
        gap_en = 1'b1;
        run_window("gaps", 7'($urandom_range(1, 127)), 0, 1'b0, -1, -1, 1'b0, e);
        gap_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int e;
        gen_prbs(7'h5A, 40);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) send_valid(tx[k], 1'b0);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.locked !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_acq before reset: got busy=%b locked=%b, expected busy=1 locked=0",
                     bus.busy, bus.locked);
        end
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.locked, bus.done, bus.lock_fail, bus.err_cnt,
             bus4.busy, bus4.locked, bus4.done, bus4.lock_fail, bus4.err_cnt} !== 28'd0) begin
            n_fails++;
            $display("FAIL async reset: got st=%b st4=%b, expected all zero before next edge",
                     {bus.busy, bus.locked, bus.done, bus.lock_fail},
                     {bus4.busy, bus4.locked, bus4.done, bus4.lock_fail});
        end
        @(negedge clk);
        rstn = 1'b1;
        // Without start the controller must stay in IDLE however many valid bits arrive.
        for (int k = 0; k < 30; k++) begin
            send_valid(tx[k], 1'b0);
            n_checks++;
            if ({bus.busy, bus.locked, bus.done, bus.lock_fail} !== 4'b0000) begin
                n_fails++;
                $display("FAIL idle after async reset at bit %0d: got st=%b, expected 0000",
                         k, {bus.busy, bus.locked, bus.done, bus.lock_fail});
            end
        end
        run_window("after_reset", 7'($urandom_range(1, 127)), 2, 1'b0, -1, -1, 1'b0, e);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        gap_en   = 1'b0;
        test_reset();
        test_clean_lock();
        test_error_count();
        test_all_zero();
        test_saturation();
        test_abort();
        test_gaps();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
